// File: rtl/spell_mem_dff.sv
// -----------------------------------------------------------------------------
// spell_mem_dff
// Flip-flop based code and data memory for the spell CPU core. The two byte
// arrays are independent. Each rising edge with select high performs one
// access, so results are ready after a single cycle. IO and EEPROM spaces are
// not backed here. Reads of those spaces return 0 and writes to them are
// dropped. The same applies to addresses beyond the end of an array.
//
// Ports
//   i_clock        system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_select       request valid; each edge with select high is one access
//   i_addr[7:0]    byte address
//   i_data_in[7:0] write data
//   i_memory_type  0=Data 1=Code 2=IO 3=EEPROM
//   i_write        1=write, 0=read
//   o_data_out     registered read data (held when no read occurs)
//   o_data_ready   registered; mirrors select from the previous edge
// -----------------------------------------------------------------------------
module spell_mem_dff #(
  parameter int CODE_WORDS = 64,
  parameter int DATA_WORDS = 64
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_select,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_data_in,
  input  logic [1:0] i_memory_type,
  input  logic       i_write,
  output logic [7:0] o_data_out,
  output logic       o_data_ready
);

  localparam int CAW = (CODE_WORDS > 1) ? $clog2(CODE_WORDS) : 1;
  localparam int DAW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

  localparam logic [1:0] MT_DATA = 2'd0;
  localparam logic [1:0] MT_CODE = 2'd1;

  logic [7:0] r_code_mem [CODE_WORDS];
  logic [7:0] r_data_mem [DATA_WORDS];
  logic [7:0] r_data_out;
  logic       r_data_ready;

  logic           w_code_hit;
  logic           w_data_hit;
  logic [CAW-1:0] w_code_idx;
  logic [DAW-1:0] w_data_idx;
  logic [7:0]     w_rd_data;

  // The full 8-bit address is range-checked before the truncated index is
  // used. This stops out-of-range addresses from aliasing onto low bytes.
  assign w_code_hit = (i_memory_type == MT_CODE) && (32'(i_addr) < CODE_WORDS);
  assign w_data_hit = (i_memory_type == MT_DATA) && (32'(i_addr) < DATA_WORDS);
  assign w_code_idx = i_addr[CAW-1:0];
  assign w_data_idx = i_addr[DAW-1:0];

  always_comb begin
    w_rd_data = 8'h00;
    if (w_code_hit)      w_rd_data = r_code_mem[w_code_idx];
    else if (w_data_hit) w_rd_data = r_data_mem[w_data_idx];
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < CODE_WORDS; i++) r_code_mem[i] <= 8'h00;
      for (int i = 0; i < DATA_WORDS; i++) r_data_mem[i] <= 8'h00;
      r_data_out   <= 8'h00;
      r_data_ready <= 1'b0;
    end else begin
      r_data_ready <= i_select;
      if (i_select) begin
        if (i_write) begin
          if (w_code_hit) r_code_mem[w_code_idx] <= i_data_in;
          if (w_data_hit) r_data_mem[w_data_idx] <= i_data_in;
        end else begin
          r_data_out <= w_rd_data;
        end
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_ready = r_data_ready;

endmodule

// File: tb/tb_spell_mem_dff.sv
module tb_spell_mem_dff;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic [7:0] addr;
  logic [7:0] din;
  logic [1:0] mtype;
  logic       wr;
  logic [7:0] dout;
  logic       rdy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       r;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  // Bench-side reference memories
  logic [7:0] m_code [64];
  logic [7:0] m_data [64];
  logic [7:0] m_dout;

  spell_mem_dff #(.CODE_WORDS(64), .DATA_WORDS(64)) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_select     (sel),
    .i_addr       (addr),
    .i_data_in    (din),
    .i_memory_type(mtype),
    .i_write      (wr),
    .o_data_out   (dout),
    .o_data_ready (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_code[i] = 8'h00;
      m_data[i] = 8'h00;
    end
    m_dout = 8'h00;
  endtask

  // One clock of stimulus: drive at negedge, update the model at the edge and
  // queue the expectation, then check it just after the edge.
  task automatic cyc(input logic s, input logic w, input logic [1:0] mt,
                     input logic [7:0] a, input logic [7:0] d, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    sel = s; wr = w; mtype = mt; addr = a; din = d;
    @(posedge clk);
    if (s) begin
      if (w) begin
        if (mt == 2'd0 && a < 8'd64) m_data[a[5:0]] = d;
        else if (mt == 2'd1 && a < 8'd64) m_code[a[5:0]] = d;
      end else begin
        if (mt == 2'd0 && a < 8'd64)      m_dout = m_data[a[5:0]];
        else if (mt == 2'd1 && a < 8'd64) m_dout = m_code[a[5:0]];
        else                              m_dout = 8'h00;
      end
    end
    e.d = m_dout; e.r = s; e.tag = tag;
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    chk({got.tag, "_dout"}, {24'd0, dout}, {24'd0, got.d});
    chk({got.tag, "_rdy"},  {31'd0, rdy},  {31'd0, got.r});
  endtask

  initial begin
    sel = 0; wr = 0; mtype = 0; addr = 0; din = 0;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("reset_dout", {24'd0, dout}, 32'd0);
    chk("reset_rdy",  {31'd0, rdy},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) cyc(1, 1, 2'd0, 8'd50, 8'd42, "wr_d50");
    cyc(1, 0, 2'd1, 8'd50, 8'd0, "rd_c50");
    cyc(1, 0, 2'd0, 8'd50, 8'd0, "rd_d50");
    cyc(1, 0, 2'd0, 8'd60, 8'd0, "rd_d60");

    // back-to-back without idle
    cyc(1, 0, 2'd0, 8'd60, 8'd0, "b2b_rd_d60");
    cyc(1, 1, 2'd1, 8'd50, 8'd99, "b2b_wr_c50");
    cyc(1, 0, 2'd1, 8'd50, 8'd0, "b2b_rd_c50");
    cyc(1, 0, 2'd0, 8'd50, 8'd0, "b2b_rd_d50");

    // out-of-range and unbacked spaces
    cyc(1, 1, 2'd0, 8'd200, 8'h55, "oor_wr_d");
    cyc(1, 1, 2'd1, 8'd200, 8'h66, "oor_wr_c");
    cyc(1, 1, 2'd0, 8'd64,  8'h77, "oor_wr_d64");
    cyc(1, 0, 2'd0, 8'd200, 8'd0, "oor_rd_d");
    cyc(1, 0, 2'd0, 8'd8,   8'd0, "alias_d8");
    cyc(1, 0, 2'd1, 8'd8,   8'd0, "alias_c8");
    cyc(1, 0, 2'd0, 8'd0,   8'd0, "alias_d0");
    cyc(1, 0, 2'd0, 8'd50,  8'd0, "rd_d50_again");
    cyc(1, 1, 2'd2, 8'd50,  8'h11, "io_wr");
    cyc(1, 1, 2'd3, 8'd50,  8'h22, "ee_wr");
    cyc(1, 0, 2'd2, 8'd50,  8'd0, "io_rd");
    cyc(1, 0, 2'd1, 8'd50,  8'd0, "rd_c50_after_io");
    cyc(1, 0, 2'd3, 8'd50,  8'd0, "ee_rd");
    cyc(1, 0, 2'd0, 8'd50,  8'd0, "rd_d50_after_ee");

    // top-of-array boundary
    cyc(1, 1, 2'd1, 8'd63, 8'hC3, "wr_c63");
    cyc(1, 1, 2'd0, 8'd63, 8'hD3, "wr_d63");
    cyc(1, 0, 2'd1, 8'd63, 8'd0, "rd_c63");
    cyc(1, 0, 2'd0, 8'd63, 8'd0, "rd_d63");

    // select drop: ready clears, data_out holds
    cyc(0, 0, 2'd1, 8'd50, 8'd0, "idle1");
    cyc(0, 1, 2'd0, 8'd10, 8'hEE, "idle2");
    cyc(1, 0, 2'd0, 8'd10, 8'd0, "rd_d10_after_idle");

    // random traffic
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 8'($urandom_range(0, 70)),
          8'($urandom), "rand");
    end

    // reset in the middle of an access
    cyc(1, 1, 2'd0, 8'd5, 8'hAA, "wr_d5");
    cyc(1, 0, 2'd0, 8'd5, 8'd0, "rd_d5");
    @(negedge clk);
    sel = 1; wr = 0; mtype = 2'd0; addr = 8'd5;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_dout", {24'd0, dout}, 32'd0);
    chk("async_rst_rdy",  {31'd0, rdy},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 2'd0, 8'd5, 8'd0, "rd_d5_after_rst");
    cyc(1, 0, 2'd1, 8'd50, 8'd0, "rd_c50_after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spell_mem_dff.md
# spell_mem_dff

Flip-flop based memory for the spell CPU core. Holds two independent byte arrays, code memory and data memory, both addressed by an 8-bit address and selected by a 2-bit memory type. It serves load/store requests from the core through a select/data_ready handshake with single-cycle latency. It is the small, synthesizable on-chip alternative to external memory backends.

## Interface
- CODE_WORDS, 64: number of bytes in code memory (addresses 0..CODE_WORDS-1).
- DATA_WORDS, 64: number of bytes in data memory (addresses 0..DATA_WORDS-1).
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- select  in  1  request valid; held high for the duration of an access.
- addr  in  8  byte address.
- data_in  in  8  write data.
- memory_type  in  2  target space:
  - 0 = Data
  - 1 = Code
  - 2 = IO
  - 3 = EEPROM
- write  in  1  1 = write, 0 = read.
- data_out  out  8  read data, registered.
- data_ready  out  1  access complete, registered.

## Operation
- Storage:
  - code_mem is CODE_WORDS×8 flops.
  - data_mem is DATA_WORDS×8 flops.
  - The two arrays are fully independent; the same address in different spaces never aliases.
- On every rising edge with select=1, one access is performed:
  - Write, type Data or Code, addr < array size: mem[addr] <= data_in. data_out is unchanged.
  - Read, type Data or Code, addr < array size: data_out <= mem[addr].
  - Read with addr ≥ array size, or type IO/EEPROM: data_out <= 0.
  - Write with addr ≥ array size, or type IO/EEPROM: ignored; no array changes.
- data_ready:
  - Set to 1 on every rising edge where select=1.
  - Cleared to 0 on every rising edge where select=0.
- Holding select high repeats the same access every cycle:
  - A repeated write is idempotent.
  - A repeated read refreshes data_out.
- The requester may change addr, write, memory_type and data_in while keeping select high. Each edge then services the inputs present at that edge. Back-to-back transactions need no idle cycle.
- Reset (reset=0, asynchronous): all code_mem and data_mem bytes, data_out and data_ready go to 0. Reset overrides any in-flight access.

## Timing
- Latency: select sampled high at edge N means the access is complete at edge N. data_ready=1 and data_out are valid after edge N, in cycle N+1.
- Write data is visible to a read sampled at the next edge.
- Deassert: select low at edge M gives data_ready=0 after edge M. data_out holds its last value.
- Inputs need to be stable only around the rising edge.
- Reset values, asserted asynchronously: data_out=0x00, data_ready=0, every memory byte 0x00.
- Reset release: the first access can be sampled at the first rising edge after reset goes high.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then write Data[50]=42 (select high 9 cycles), then read Code[50] -> data_out=0, data_ready=1 one cycle after select.
- Read Data[50] -> data_out=42. Read Data[60] (never written) -> data_out=0.
- Back-to-back with select held high: read Data[60], then immediately write Code[50]=99, then read Code[50] -> 99. Data[50] still reads 42.
- Read and write at addr 200 (out of range), and to type IO/EEPROM -> reads return 0, writes leave both arrays unchanged, data_ready still asserts.
- Drop select for 2 cycles -> data_ready=0 after the first edge with select low; data_out holds the last value.
- Assert reset mid-access after writing Data[5]=0xAA -> data_out and data_ready go to 0 immediately; after release, Data[5] reads 0.
